pipe_mw_reg: RTL and testbench

- MEM→WB pipeline register of the 32-bit pipelined processor.
- Captures the memory-stage control bits (register write, memory-to-register select), the memory read data and the ALU result on each rising clock edge.
- Presents them to the write-back stage one cycle later.
- Asynchronous clear flushes the stage to a bubble: all outputs zero, so no register write occurs.

---
 rtl/pipe_mw_reg.sv | 32 +++
 tb/tb_pipe_mw_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_mw_reg.sv
// MEM->WB pipeline register: control bits, memory read data and ALU result.
// Asynchronous clear turns the stage into a bubble (no register write).
module pipe_mw_reg #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             REG_WRITE_M,
   input  logic             MEM_TO_REG_M,
   input  logic [WIDTH-1:0] MEM_RD_M,
   input  logic [WIDTH-1:0] ALU_OUT_M,
   output logic             REG_WRITE_W,
   output logic             MEM_TO_REG_W,
   output logic [WIDTH-1:0] MEM_RD_W,
   output logic [WIDTH-1:0] ALU_OUT_W
);

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         REG_WRITE_W  <= 1'b0;
         MEM_TO_REG_W <= 1'b0;
         MEM_RD_W     <= '0;
         ALU_OUT_W    <= '0;
      end else begin
         REG_WRITE_W  <= REG_WRITE_M;
         MEM_TO_REG_W <= MEM_TO_REG_M;
         MEM_RD_W     <= MEM_RD_M;
         ALU_OUT_W    <= ALU_OUT_M;
      end
   end

endmodule

// File: tb/tb_pipe_mw_reg.sv
// Scoreboard bench for pipe_mw_reg: stimulus pushes expected stage contents,
// a monitor pops one entry after every rising edge and compares.
module tb_pipe_mw_reg;

   typedef struct packed {
      logic        rw;
      logic        mr;
      logic [31:0] rd;
      logic [31:0] alu;
   } mw_t;

   logic        CLK;
   logic        CLR;
   logic        REG_WRITE_M;
   logic        MEM_TO_REG_M;
   logic [31:0] MEM_RD_M;
   logic [31:0] ALU_OUT_M;
   logic        REG_WRITE_W;
   logic        MEM_TO_REG_W;
   logic [31:0] MEM_RD_W;
   logic [31:0] ALU_OUT_W;

   mw_t out;
   mw_t cur;
   mw_t zero;
   mw_t q[$];
   int  tests;
   int  fails;

   pipe_mw_reg #(.WIDTH(32)) dut (
      .CLK(CLK),
      .CLR(CLR),
      .REG_WRITE_M(REG_WRITE_M),
      .MEM_TO_REG_M(MEM_TO_REG_M),
      .MEM_RD_M(MEM_RD_M),
      .ALU_OUT_M(ALU_OUT_M),
      .REG_WRITE_W(REG_WRITE_W),
      .MEM_TO_REG_W(MEM_TO_REG_W),
      .MEM_RD_W(MEM_RD_W),
      .ALU_OUT_W(ALU_OUT_W)
   );

   assign out = {REG_WRITE_W, MEM_TO_REG_W, MEM_RD_W, ALU_OUT_W};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input mw_t act, input mw_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input mw_t v);
      REG_WRITE_M  = v.rw;
      MEM_TO_REG_M = v.mr;
      MEM_RD_M     = v.rd;
      ALU_OUT_M    = v.alu;
   endtask

   // drive one transfer: outputs must still show the previous stage
   task automatic drive(input mw_t v);
      set_in(v);
      q.push_back(v);
      #1;
      chk("pre_edge", out, cur);
      cur = v;
   endtask

   // monitor: one capture per rising edge while transfers are in flight
   always @(posedge CLK) begin
      mw_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("capture", out, e);
      end
   end

   initial begin
      mw_t v;
      int  n;
      tests = 0;
      fails = 0;
      zero  = '0;
      cur   = '0;
      CLR   = 1'b0;
      set_in('0);
      #1;
      CLR = 1'b1;
      set_in({1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678});
      #1;
      chk("reset_async", out, zero);
      repeat (3) begin
         @(posedge CLK);
         #1;
         chk("reset_hold", out, zero);
      end

      @(negedge CLK);
      CLR = 1'b0;
      drive({1'b1, 1'b0, 32'hA5A5A5A5, 32'h00000010});

      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         v.rw  = 1'($urandom);
         v.mr  = 1'($urandom);
         v.rd  = $urandom;
         v.alu = $urandom;
         drive(v);
      end

      @(negedge CLK);
      drive({1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF});
      @(negedge CLK);
      drive({1'b1, 1'b0, 32'h01234567, 32'h89ABCDEF});
      CLR = 1'b1;
      #1;
      chk("mid_clear", out, zero);
      #1;
      CLR = 1'b0;

      @(negedge CLK);
      drive({1'b1, 1'b1, 32'hFFFFFFFF, 32'h80000000});
      @(negedge CLK);
      drive({1'b0, 1'b1, 32'h00000000, 32'h7FFFFFFF});

      @(negedge CLK);
      v = {1'b1, 1'b0, 32'h0BADF00D, 32'h00000001};
      set_in(v);
      #1;
      chk("glitch_pre", out, cur);
      ALU_OUT_M = 32'h2;
      #1;
      chk("glitch_hold", out, cur);
      ALU_OUT_M = 32'h3;
      v.alu = 32'h3;
      q.push_back(v);
      cur = v;

      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(negedge CLK);
         n++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
